seq_signed_mult_param: RTL and testbench

Parametrised sequential signed multiplier core, the next generation of the board multiplier datapath. It takes two WIDTH-bit two's-complement operands on a start/busy/done handshake and produces the full 2·WIDTH-bit signed product by shift-and-add on magnitudes. Its new features are optional early termination, synchronous abort, and zero-aware sign and zero flags. It sits between the button/control layer and the bin-to-BCD/display path.

---
 rtl/seq_signed_mult_param_pkg.sv | 26 ++
 rtl/seq_signed_mult_param_if.sv | 26 ++
 rtl/seq_signed_mult_param_abs.sv | 11 +
 rtl/seq_signed_mult_param.sv | 121 ++++++++++++
 tb/tb_seq_signed_mult_param.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_signed_mult_param_pkg.sv
// Shared types and constants for the sequential signed multiplier.
package mult_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Iteration counter width for a given operand width (must reach WIDTH)
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Counter width for the default 8-bit build
    localparam int CNT_W_DEFAULT = $clog2(8 + 1);

    // Output values after reset: an empty product reads as zero
    localparam logic RST_BUSY  = 1'b0;
    localparam logic RST_DONE  = 1'b0;
    localparam logic RST_SIGN  = 1'b0;
    localparam logic RST_ZFLAG = 1'b1;

endpackage

// File: rtl/seq_signed_mult_param_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface seq_signed_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                          start;
    logic                          abort;
    logic signed [WIDTH-1:0]       multiplier;
    logic signed [WIDTH-1:0]       multiplicand;
    logic                          busy;
    logic                          done;
    logic signed [2*WIDTH-1:0]     product;
    logic                          sign;
    logic                          zflag;

    // Requester side
    modport master (
        output start, abort, multiplier, multiplicand,
        input  busy, done, product, sign, zflag
    );

    // Multiplier core side
    modport slave (
        input  start, abort, multiplier, multiplicand,
        output busy, done, product, sign, zflag
    );
endinterface

// File: rtl/seq_signed_mult_param_abs.sv
// Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
// which still fits because the result is read as unsigned.
module abs_val #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a_i,
    output logic        [WIDTH-1:0] mag_o
);
    // Negate only negative inputs
    assign mag_o = a_i[WIDTH-1] ? $unsigned(-a_i) : $unsigned(a_i);
endmodule

// File: rtl/seq_signed_mult_param.sv
// Sequential signed multiplier: shift-and-add on operand magnitudes with the
// sign applied at the end. Optional early exit once the remaining multiplier
// magnitude is zero; synchronous abort from any busy state.
module seq_signed_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    seq_signed_mult_param_if.slave   bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t                   state_q;
    logic signed [WIDTH-1:0]  mpr_op_q;
    logic signed [WIDTH-1:0]  mcd_op_q;
    logic                     neg_q;
    logic        [WIDTH-1:0]  mpr_q;
    logic        [WIDTH-1:0]  mcd_q;
    logic        [WIDTH-1:0]  mpr_abs;
    logic        [WIDTH-1:0]  mcd_abs;
    logic        [PW-1:0]     acc_q;
    logic        [PW-1:0]     acc_d;
    logic        [CNT_W-1:0]  cnt_q;
    logic signed [PW-1:0]     product_q;
    logic signed [PW-1:0]     result_d;
    logic                     busy_q;
    logic                     done_q;
    logic                     sign_q;
    logic                     zflag_q;
    logic                     run_end;

    abs_val #(.WIDTH(WIDTH)) u_abs_mpr (.a_i(mpr_op_q), .mag_o(mpr_abs));
    abs_val #(.WIDTH(WIDTH)) u_abs_mcd (.a_i(mcd_op_q), .mag_o(mcd_abs));

    // Next accumulator, signed result and loop-exit condition
    always_comb begin
        acc_d = acc_q;
        if (mpr_q[0]) begin
            acc_d = acc_q + ({{WIDTH{1'b0}}, mcd_q} << cnt_q);
        end
        result_d = neg_q ? -$signed(acc_q) : $signed(acc_q);
        run_end  = ((EARLY_TERM != 1'b0) && (mpr_q == '0)) || (cnt_q == CNT_MAX);
    end

    // Controller and datapath registers; abort overrides every busy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mpr_op_q  <= '0;
            mcd_op_q  <= '0;
            neg_q     <= 1'b0;
            mpr_q     <= '0;
            mcd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= RST_BUSY;
            done_q    <= RST_DONE;
            sign_q    <= RST_SIGN;
            zflag_q   <= RST_ZFLAG;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            mpr_op_q <= bus.multiplier;
                            mcd_op_q <= bus.multiplicand;
                            neg_q    <= bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1];
                            busy_q   <= 1'b1;
                            state_q  <= LOAD;
                        end
                    end
                    LOAD: begin
                        mpr_q   <= mpr_abs;
                        mcd_q   <= mcd_abs;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (run_end) begin
                            state_q <= FINISH;
                        end else begin
                            acc_q <= acc_d;
                            mpr_q <= mpr_q >> 1;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    FINISH: begin
                        product_q <= result_d;
                        sign_q    <= (result_d != '0) && neg_q;
                        zflag_q   <= (result_d == '0);
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.sign    = sign_q;
    assign bus.zflag   = zflag_q;

endmodule

// File: tb/tb_seq_signed_mult_param.sv
// Bench for seq_signed_mult_param: 8-bit early-exit, 8-bit fixed-count and
// 16-bit early-exit instances against an arithmetic reference model.
module tb_seq_signed_mult_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_prod [3];

    always #5 clk = ~clk;

    seq_signed_mult_param_if #(.WIDTH(8))  ifa ();
    seq_signed_mult_param_if #(.WIDTH(8))  ifb ();
    seq_signed_mult_param_if #(.WIDTH(16)) ifc ();

    seq_signed_mult_param #(.WIDTH(8),  .EARLY_TERM(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_signed_mult_param #(.WIDTH(8),  .EARLY_TERM(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_signed_mult_param #(.WIDTH(16), .EARLY_TERM(1'b1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    // Reference: RUN cycles from the operand rules
    function automatic int model_runs(input int w, input bit et, input int a);
        int mag;
        int b;
        if (!et) return w + 1;
        mag = (a < 0) ? -a : a;
        b = 0;
        for (int i = 0; i < 31; i++) if ((mag >> i) != 0) b = i + 1;
        return b + 1;
    endfunction

    task automatic drive(input int which, input logic st, input logic ab, input int a, input int b);
        case (which)
            0: begin ifa.start = st; ifa.abort = ab; ifa.multiplier = 8'(a);  ifa.multiplicand = 8'(b);  end
            1: begin ifb.start = st; ifb.abort = ab; ifb.multiplier = 8'(a);  ifb.multiplicand = 8'(b);  end
            default: begin ifc.start = st; ifc.abort = ab; ifc.multiplier = 16'(a); ifc.multiplicand = 16'(b); end
        endcase
    endtask

    task automatic sample(input int which, output logic d, output logic bz,
                          output logic sg, output logic zf, output int p);
        case (which)
            0: begin d = ifa.done; bz = ifa.busy; sg = ifa.sign; zf = ifa.zflag; p = int'(ifa.product); end
            1: begin d = ifb.done; bz = ifb.busy; sg = ifb.sign; zf = ifb.zflag; p = int'(ifb.product); end
            default: begin d = ifc.done; bz = ifc.busy; sg = ifc.sign; zf = ifc.zflag; p = int'(ifc.product); end
        endcase
    endtask

    task automatic run_mult(input int which, input int a, input int b, input string name);
        int   w;
        bit   et;
        int   exp_p;
        int   exp_lat;
        int   k;
        int   p;
        logic d, bz, sg, zf;
        bit   seen;
        w       = (which == 2) ? 16 : 8;
        et      = (which != 1);
        exp_p   = a * b;
        exp_lat = model_runs(w, et, a) + 2;
        @(negedge clk);
        drive(which, 1'b1, 1'b0, a, b);
        @(posedge clk);
        #1;
        drive(which, 1'b0, 1'b0, a, b);
        sample(which, d, bz, sg, zf, p);
        n_checks++;
        if (bz !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, bz);
        end
        k = 0;
        seen = 0;
        while (!seen && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            sample(which, d, bz, sg, zf, p);
            if (d === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s done_timeout: got no done expected done within 100 cycles", name);
        end else begin
            n_checks++;
            if (k != exp_lat) begin
                n_errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat);
            end
            n_checks++;
            if (p !== exp_p) begin
                n_errors++;
                $display("FAIL %s product: got %0d expected %0d", name, p, exp_p);
            end
            n_checks++;
            if (sg !== logic'(exp_p < 0)) begin
                n_errors++;
                $display("FAIL %s sign: got %b expected %b", name, sg, exp_p < 0);
            end
            n_checks++;
            if (zf !== logic'(exp_p == 0)) begin
                n_errors++;
                $display("FAIL %s zflag: got %b expected %b", name, zf, exp_p == 0);
            end
            n_checks++;
            if (bz !== 1'b0) begin
                n_errors++;
                $display("FAIL %s busy_at_done: got %b expected 0", name, bz);
            end
        end
        last_prod[which] = exp_p;
    endtask

    task automatic check_reset_outputs(input int which, input string name);
        logic d, bz, sg, zf;
        int   p;
        sample(which, d, bz, sg, zf, p);
        n_checks++;
        if (p !== 0)     begin n_errors++; $display("FAIL %s product: got %0d expected 0", name, p); end
        n_checks++;
        if (bz !== 1'b0) begin n_errors++; $display("FAIL %s busy: got %b expected 0", name, bz); end
        n_checks++;
        if (d !== 1'b0)  begin n_errors++; $display("FAIL %s done: got %b expected 0", name, d); end
        n_checks++;
        if (sg !== 1'b0) begin n_errors++; $display("FAIL %s sign: got %b expected 0", name, sg); end
        n_checks++;
        if (zf !== 1'b1) begin n_errors++; $display("FAIL %s zflag: got %b expected 1", name, zf); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0, "reset_a");
        check_reset_outputs(2, "reset_c");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) last_prod[i] = 0;
    endtask

    task automatic test_directed();
        run_mult(0, 3, -2, "p3_m2");
        run_mult(0, -128, -128, "m128_m128_et1");
        run_mult(1, -128, -128, "m128_m128_et0");
        run_mult(0, 0, -5, "zero_mpr");
        run_mult(0, 7, 0, "zero_mcd");
        run_mult(1, 3, -2, "p3_m2_et0");
        run_mult(0, 127, -128, "max_min");
    endtask

    task automatic test_abort();
        int   prev;
        int   ndone;
        int   p;
        logic d, bz, sg, zf;
        prev = last_prod[0];
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 100, 100);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 100, 100);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b1, 100, 100);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 100, 100);
        sample(0, d, bz, sg, zf, p);
        n_checks++;
        if (bz !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", bz); end
        n_checks++;
        if (p !== prev)  begin n_errors++; $display("FAIL abort_product: got %0d expected %0d", p, prev); end
        ndone = (d === 1'b1) ? 1 : 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            sample(0, d, bz, sg, zf, p);
            if (d === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0)  begin n_errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); end
        n_checks++;
        if (p !== prev)  begin n_errors++; $display("FAIL abort_hold: got %0d expected %0d", p, prev); end
        run_mult(0, 100, 100, "after_abort");
    endtask

    task automatic test_back_to_back();
        int   a1, b1, a2, b2;
        int   k;
        int   p;
        int   extra;
        bit   seen;
        logic d, bz, sg, zf;
        a1 = -7; b1 = 9; a2 = 12; b2 = -11;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, a1, b1);
        @(posedge clk);
        #1;
        k = 0;
        seen = 0;
        while (!seen && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            sample(0, d, bz, sg, zf, p);
            if (d === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || k != model_runs(8, 1'b1, a1) + 2) begin
            n_errors++;
            $display("FAIL b2b_first_latency: got %0d expected %0d", k, model_runs(8, 1'b1, a1) + 2);
        end
        n_checks++;
        if (p !== a1 * b1) begin n_errors++; $display("FAIL b2b_first_product: got %0d expected %0d", p, a1 * b1); end
        drive(0, 1'b1, 1'b0, a2, b2);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, a2, b2);
        sample(0, d, bz, sg, zf, p);
        n_checks++;
        if (bz !== 1'b1 || d !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_no_gap: got busy=%b done=%b expected busy=1 done=0", bz, d);
        end
        k = 0;
        seen = 0;
        while (!seen && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            sample(0, d, bz, sg, zf, p);
            if (d === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || k != model_runs(8, 1'b1, a2) + 2) begin
            n_errors++;
            $display("FAIL b2b_second_latency: got %0d expected %0d", k, model_runs(8, 1'b1, a2) + 2);
        end
        n_checks++;
        if (p !== a2 * b2) begin n_errors++; $display("FAIL b2b_second_product: got %0d expected %0d", p, a2 * b2); end
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            sample(0, d, bz, sg, zf, p);
            if (d === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin n_errors++; $display("FAIL b2b_extra_done: got %0d expected 0", extra); end
        last_prod[0] = a2 * b2;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, -50, 3);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, -50, 3);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs(0, "rst_midrun");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) last_prod[i] = 0;
        run_mult(0, -50, 3, "after_rst");
    endtask

    task automatic test_random();
        int a;
        int b;
        run_mult(2, -32768, -32768, "w16_min_min");
        run_mult(2, 32767, -32768, "w16_max_min");
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            run_mult(2, a, b, "w16_rand");
        end
        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            run_mult(0, a, b, "w8_rand_et1");
            run_mult(1, a, b, "w8_rand_et0");
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 0, 0);
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
